// File: rtl/master_ctrl_pkg.sv
// master_ctrl_pkg: shared phase encoding and default geometry for the matmul sequencer
package master_ctrl_pkg;
  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_COMPUTE_LATENCY = 32;
  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, DRAIN, LATCH, COMPUTE, DONE} state_e;
endpackage

// File: rtl/master_lane_mask.sv
// master_lane_mask: thermometer mask with the low num+1 bits set, forced to zero when en is low
module master_lane_mask #(
  parameter int WIDTH = 16
) (
  input  logic                       en,
  input  logic [$clog2(WIDTH)-1:0]   num,
  output logic [WIDTH-1:0]           mask
);
  localparam int NW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;
  always_comb mask = en ? ONES >> (NW'(WIDTH - 1) - num) : '0;
endmodule

// File: rtl/master_matmul_sequencer.sv
// master_matmul_sequencer: fill -> drain -> latch -> compute phase sequencer for one tiled matmul
module master_matmul_sequencer
  import master_ctrl_pkg::*;
#(
  parameter int SYS_ARR_ROWS    = DEF_ROWS,
  parameter int SYS_ARR_COLS    = DEF_COLS,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int COMPUTE_LATENCY = DEF_COMPUTE_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [$clog2(SYS_ARR_ROWS)-1:0] num_row,
  input  logic [$clog2(SYS_ARR_COLS)-1:0] num_col,
  input  logic [ADDR_WIDTH-1:0]           num_in,
  input  logic [ADDR_WIDTH-1:0]           input_base,
  input  logic [ADDR_WIDTH-1:0]           output_base,
  output logic                            busy,
  output logic                            done,
  output logic                            fill_start,
  input  logic                            fill_done,
  output logic                            drain_en,
  output logic                            weight_latch,
  output logic [SYS_ARR_ROWS-1:0]         inputMem_rd_en,
  output logic [ADDR_WIDTH-1:0]           inputMem_rd_addr,
  output logic [SYS_ARR_COLS-1:0]         outputMem_wr_en,
  output logic [ADDR_WIDTH-1:0]           outputMem_wr_addr
);
  localparam int RW = $clog2(SYS_ARR_ROWS);
  localparam int CLW = $clog2(SYS_ARR_COLS);
  localparam int CW_A = $clog2(2 ** ADDR_WIDTH + COMPUTE_LATENCY);
  localparam int CW_D = $clog2(SYS_ARR_ROWS + 1);
  localparam int CW = CW_A > CW_D ? CW_A : CW_D;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, last_c;
  logic [RW-1:0] num_row_q, num_row_d;
  logic [CLW-1:0] num_col_q, num_col_d;
  logic [ADDR_WIDTH-1:0] num_in_q, num_in_d, in_base_q, in_base_d, out_base_q, out_base_d;
  logic rd_on, wr_on;
  assign last_c = CW'(COMPUTE_LATENCY) + CW'(num_in_q);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    num_row_d = num_row_q;
    num_col_d = num_col_q;
    num_in_d = num_in_q;
    in_base_d = in_base_q;
    out_base_d = out_base_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL_REQ;
        cnt_d = '0;
        num_row_d = num_row;
        num_col_d = num_col;
        num_in_d = num_in;
        in_base_d = input_base;
        out_base_d = output_base;
      end
      FILL_REQ: begin
        state_d = FILL_WAIT;
        cnt_d = '0;
      end
      // first wait cycle is blanked: the controller's done only drops one cycle after its start
      FILL_WAIT: if (cnt_q == '0) cnt_d = CW'(1);
        else if (fill_done) begin
          state_d = DRAIN;
          cnt_d = '0;
        end
      DRAIN: if (cnt_q == CW'(SYS_ARR_ROWS - 1)) begin
        state_d = LATCH;
        cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      LATCH: begin
        state_d = COMPUTE;
        cnt_d = '0;
      end
      COMPUTE: if (cnt_q == last_c) state_d = DONE;
        else cnt_d = cnt_q + CW'(1);
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      num_row_q <= '0;
      num_col_q <= '0;
      num_in_q <= '0;
      in_base_q <= '0;
      out_base_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      num_row_q <= num_row_d;
      num_col_q <= num_col_d;
      num_in_q <= num_in_d;
      in_base_q <= in_base_d;
      out_base_q <= out_base_d;
    end
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    fill_start = state_q == FILL_REQ;
    drain_en = state_q == DRAIN;
    weight_latch = state_q == LATCH;
    rd_on = state_q == COMPUTE && cnt_q <= CW'(num_in_q);
    wr_on = state_q == COMPUTE && cnt_q >= CW'(COMPUTE_LATENCY) && cnt_q <= last_c;
    inputMem_rd_addr = rd_on ? in_base_q + cnt_q[ADDR_WIDTH-1:0] : '0;
    outputMem_wr_addr = wr_on ? out_base_q + ADDR_WIDTH'(cnt_q - CW'(COMPUTE_LATENCY)) : '0;
  end
  master_lane_mask #(.WIDTH(SYS_ARR_ROWS)) u_row_mask (.en(rd_on), .num(num_row_q), .mask(inputMem_rd_en));
  master_lane_mask #(.WIDTH(SYS_ARR_COLS)) u_col_mask (.en(wr_on), .num(num_col_q), .mask(outputMem_wr_en));
endmodule

// File: tb/tb_master_matmul_sequencer.sv
// tb_master_matmul_sequencer: per-cycle comparison of every output against a phase-timeline model
module tb_master_matmul_sequencer;
  logic clk = 0, reset = 1, start = 0, fill_done = 1;
  logic [3:0] num_row = 0, num_col = 0;
  logic [7:0] num_in = 0, input_base = 0, output_base = 0;
  logic busy, done, fill_start, drain_en, weight_latch;
  logic [15:0] rd_en, wr_en;
  logic [7:0] rd_addr, wr_addr;
  logic [52:0] obs;
  int errors = 0, checks = 0;
  int j_nr, j_nc, j_n, j_ib, j_ob, j_w, lo_s, lo_l;

  master_matmul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_row(num_row), .num_col(num_col),
    .num_in(num_in), .input_base(input_base), .output_base(output_base), .busy(busy),
    .done(done), .fill_start(fill_start), .fill_done(fill_done), .drain_en(drain_en),
    .weight_latch(weight_latch), .inputMem_rd_en(rd_en), .inputMem_rd_addr(rd_addr),
    .outputMem_wr_en(wr_en), .outputMem_wr_addr(wr_addr)
  );

  always #5 clk = ~clk;
  assign obs = {busy, done, fill_start, drain_en, weight_latch, rd_en, rd_addr, wr_en, wr_addr};

  function automatic bit fd(int k);
    return !(k >= lo_s && k < lo_s + lo_l);
  endfunction

  // expected outputs k cycles after the start-accepting edge
  function automatic logic [52:0] expv(int k);
    int c0 = j_w + 18;
    int cyc = k - c0;
    logic b, d, fs, de, wl;
    logic [15:0] re = '0, we = '0;
    logic [7:0] ra = '0, wa = '0;
    b = k >= 1 && k <= c0 + 33 + j_n;
    d = k == c0 + 33 + j_n;
    fs = k == 1;
    de = k > j_w && k <= j_w + 16;
    wl = k == j_w + 17;
    if (k >= c0 && cyc <= j_n) begin
      re = 16'((32'd1 << (j_nr + 1)) - 1);
      ra = 8'(j_ib + cyc);
    end
    if (cyc >= 32 && cyc <= 32 + j_n) begin
      we = 16'((32'd1 << (j_nc + 1)) - 1);
      wa = 8'(j_ob + cyc - 32);
    end
    return {b, d, fs, de, wl, re, ra, we, wa};
  endfunction

  task automatic check(string tag, logic [52:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_job(int nr, int nc, int n, int ib, int ob, int ls, int ll, bit poke, int abort);
    int c0, last;
    j_nr = nr; j_nc = nc; j_n = n; j_ib = ib; j_ob = ob; lo_s = ls; lo_l = ll;
    j_w = 3;
    while (!fd(j_w)) j_w++;
    c0 = j_w + 18;
    last = c0 + 34 + n;
    num_row = 4'(nr); num_col = 4'(nc); num_in = 8'(n);
    input_base = 8'(ib); output_base = 8'(ob);
    reset = 0; start = 1; fill_done = 1;
    @(posedge clk); #1;
    start = 0;
    num_row = 4'($urandom); num_col = 4'($urandom); num_in = 8'($urandom);
    input_base = 8'($urandom); output_base = 8'($urandom);
    for (int k = 1; k <= last; k++) begin
      check($sformatf("n=%0d k=%0d", n, k), expv(k));
      fill_done = fd(k);
      start = poke && (k == c0 + 2 || k == 5);
      if (poke && k == c0 + 2) num_in = 8'hFF;
      if (abort >= 0 && k == c0 + abort) begin
        reset = 1;
        @(posedge clk); #1;
        check("abort", '0);
        reset = 0;
        @(posedge clk); #1;
        check("post-abort", '0);
        return;
      end
      @(posedge clk); #1;
    end
    start = 0;
  endtask

  initial begin
    reset = 1; start = 1;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset", '0);
    end
    run_job(3, 3, 4, 'h10, 'h80, 2, 18, 1, -1);
    run_job(3, 3, 4, 'h10, 'h80, 2, 18, 0, -1);
    run_job(5, 9, 4, 'h20, 'h40, 3, 100, 0, -1);
    run_job(1, 2, 3, 'hFE, 'h05, 2, 5, 0, -1);
    run_job(15, 15, 255, 'h33, 'hF0, 2, 3, 0, -1);
    run_job(3, 3, 20, 'h00, 'h10, 2, 4, 0, 10);
    run_job(3, 3, 4, 'h10, 'h80, 2, 18, 0, -1);
    repeat (6) begin
      run_job($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 40),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(2, 4),
              $urandom_range(0, 25), $urandom_range(0, 1), -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
